// File: rtl/mod_engine_pkg.sv
// Shared types and defaults for the sequential modulus engine.
package mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/mod_engine_if.sv
// Request/response bundle between a requester and mod_engine.
// The quotient signal exists only when MOD_QUOTIENT_EN is defined.
interface mod_engine_if #(parameter int WIDTH = mod_pkg::DEF_WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] result;
`ifdef MOD_QUOTIENT_EN
  logic [WIDTH-1:0] quotient;
`endif

  modport master (
    output start, a, b,
`ifdef MOD_QUOTIENT_EN
    input  quotient,
`endif
    input  busy, done, div_by_zero, result
  );

  modport slave (
    input  start, a, b,
`ifdef MOD_QUOTIENT_EN
    output quotient,
`endif
    output busy, done, div_by_zero, result
  );

endinterface

// File: rtl/mod_engine_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract if it fits.
module mod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  assign t    = {rem, dvd_msb};
  assign diff = t - {1'b0, dsr};
  // rem < dsr on entry, so a clear borrow bit means t >= dsr and the difference fits WIDTH bits.
  assign qbit    = ~diff[WIDTH];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/mod_engine.sv
// Sequential unsigned a mod b, one quotient bit per cycle, with start/busy/done handshake.
// Define MOD_QUOTIENT_EN to also expose the quotient.
module mod_engine
  import mod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         CLK,
  input  logic         reset,
  mod_engine_if.slave  bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] result_q;
  logic             dz_q;
  logic             qbit;
  logic             accept;
  logic             last_step;

  assign accept    = (state == IDLE) && bus.start;
  assign last_step = (state == STEP) && (cnt == '0);
  assign dvd_nxt   = {dvd[WIDTH-2:0], qbit};

  mod_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[WIDTH-1]),
    .dsr     (dsr),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.start ? ((bus.b == '0) ? DONE : STEP) : IDLE;
      STEP:    state_nxt = (cnt == '0) ? DONE : STEP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == STEP);
    bus.done = (state == DONE);
  end

  // Working registers carry no reset: they are always loaded on accept before use.
  always_ff @(posedge CLK) begin
    if (accept) begin
      dvd <= bus.a;
      dsr <= bus.b;
      rem <= '0;
    end else if (state == STEP) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt      <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      cnt  <= CNT_INIT;
      dz_q <= (bus.b == '0);
      if (bus.b == '0) result_q <= bus.a;
    end else if (state == STEP) begin
      cnt <= cnt - 1'b1;
      if (last_step) result_q <= rem_nxt;
    end
  end

  assign bus.result      = result_q;
  assign bus.div_by_zero = dz_q;

`ifdef MOD_QUOTIENT_EN
  logic [WIDTH-1:0] quot_q;

  always_ff @(posedge CLK) begin
    if (reset)                          quot_q <= '0;
    else if (accept && (bus.b == '0))   quot_q <= '1;
    else if (last_step)                 quot_q <= dvd_nxt;
  end

  assign bus.quotient = quot_q;
`endif

endmodule
